alu_issue_queue: RTL and testbench
==================================

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued operation entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  producer offers an operation this cycle.
REQ-005 SHALL have port in_ready  output  1  queue can accept an operation this cycle.
REQ-006 SHALL have port in_A  input  4  operand A.
REQ-007 SHALL have port in_B  input  4  operand B.
REQ-008 SHALL have port in_fncode  input  8  one-hot function code for the downstream encoder/ALU stage.
REQ-009 SHALL have port stall  input  1  downstream pipeline cannot take an operation this cycle.
REQ-010 SHALL have port out_valid  output  1  out_A/out_B/out_fncode carry a new operation this cycle.
REQ-011 SHALL have port out_A  output  4  issued operand A (registered).
REQ-012 SHALL have port out_B  output  4  issued operand B (registered).
REQ-013 SHALL have port out_fncode  output  8  issued one-hot function code (registered).
REQ-014 SHALL have port count  output  5  current number of queued entries, 0..DEPTH.
REQ-015 SHALL have port reject  output  1  one-cycle pulse: previous accepted handshake carried a non-one-hot fncode.
REQ-016 SHALL have port reject_cnt  output  8  running count of rejected operations.

Function
REQ-017 SHALL drive in_ready = (count < DEPTH) combinationally; in_ready SHALL NOT depend on stall or on a same-cycle pop.
REQ-018 SHALL treat a handshake as in_valid && in_ready at a rising edge.
REQ-019 SHALL, on a handshake with in_fncode exactly one-hot, write {in_A,in_B,in_fncode} at the tail and increment count.
REQ-020 SHALL, on a handshake with in_fncode zero or multi-hot, discard the operation, leave count unchanged, assert reject for the next cycle only, and increment reject_cnt saturating at 255.
REQ-021 SHALL assert no reject and change no state when in_valid is high but in_ready is low.
REQ-022 SHALL pop the head at a rising edge when count > 0 and stall = 0: out_A/out_B/out_fncode load head fields, out_valid = 1 for the following cycle, count decrements.
REQ-023 SHALL, at a rising edge with count = 0 or stall = 1, set out_valid = 0 and hold out_A/out_B/out_fncode unchanged.
REQ-024 SHALL issue in strict FIFO order, at most one push and one pop per cycle.
REQ-025 SHALL have minimum latency of two edges: entry pushed at edge N is earliest popped at edge N+1, visible on outputs after N+1; no empty-queue bypass.
REQ-026 SHALL, on simultaneous push and pop, keep count unchanged and issue the old head, never the entry being written.
REQ-027 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-028 SHALL only pop entries previously written; stall with count = DEPTH holds all entries intact.

Reset
REQ-029 SHALL, when rst = 1 at a rising edge, clear count, pointers, out_valid, out_A, out_B, out_fncode, reject and reject_cnt to 0, overriding any same-cycle push or pop.
REQ-030 SHALL discard all queued entries on reset mid-operation; in_ready = 1 in the cycle after reset.

Verification
REQ-031 SHALL cover: reset, push A=5,B=6,fncode=8'h01 with stall=0 -> after the next edge out_valid=1, out_A=5, out_B=6, out_fncode=8'h01, count=0.
REQ-032 SHALL cover: stall=1, push 4 ops (A=1..4) -> count=4, in_ready=0, fifth offer ignored, out_valid=0; release stall -> A=1,2,3,4 issued on four consecutive cycles.
REQ-033 SHALL cover: push fncode=8'h03, then 8'h00 -> reject pulses one cycle each, reject_cnt=2, count=0, out_valid never asserted.
REQ-034 SHALL cover: continuous push/pop for 10 ops (A=0..9, fncode=8'h02) with stall=0 -> outputs A=0..9 in order, count stays 1, pointers wrap twice.
REQ-035 SHALL cover: 3 entries queued, rst=1 for one edge -> count=0, out_valid=0, reject_cnt=0; next push issues normally.
REQ-036 SHALL cover: 300 invalid-fncode handshakes -> reject_cnt saturates at 255.

Source files
------------

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - FIFO issue queue feeding one-hot ALU operations downstream
// Illegal (zero or multi-hot) function codes are dropped at the input and counted.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_A,
    input  logic [3:0] in_B,
    input  logic [7:0] in_fncode,
    input  logic       stall,
    output logic       out_valid,
    output logic [3:0] out_A,
    output logic [3:0] out_B,
    output logic [7:0] out_fncode,
    output logic [4:0] count,
    output logic       reject,
    output logic [7:0] reject_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          fn_onehot;
    logic          handshake;
    logic          push;
    logic          pop;
    logic          bad_op;
    logic [15:0]   head;

    assign in_ready  = (count < 5'(DEPTH));
    assign fn_onehot = (in_fncode != 8'd0) && ((in_fncode & (in_fncode - 8'd1)) == 8'd0);
    assign handshake = in_valid && in_ready;
    assign push      = handshake && fn_onehot;
    assign bad_op    = handshake && !fn_onehot;
    // Pop decision uses the pre-push count, so a freshly written entry is never bypassed.
    assign pop       = (count != 5'd0) && !stall;
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_A, in_B, in_fncode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= 5'd0;
            out_valid  <= 1'b0;
            out_A      <= 4'd0;
            out_B      <= 4'd0;
            out_fncode <= 8'd0;
            reject     <= 1'b0;
            reject_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_A      <= head[15:12];
                out_B      <= head[11:8];
                out_fncode <= head[7:0];
                out_valid  <= 1'b1;
            end else begin
                out_valid  <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            reject <= bad_op;
            if (bad_op && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - randomized self-checking bench for alu_issue_queue
// Reference model is a plain queue plus output registers updated once per edge.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_A;
    logic [3:0] in_B;
    logic [7:0] in_fncode;
    logic       stall;
    logic       out_valid;
    logic [3:0] out_A;
    logic [3:0] out_B;
    logic [7:0] out_fncode;
    logic [4:0] count;
    logic       reject;
    logic [7:0] reject_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_q [$];
    bit          m_ov;
    logic [3:0]  m_a;
    logic [3:0]  m_b;
    logic [7:0]  m_f;
    bit          m_rej;
    int          m_rcnt;

    logic [31:0] dut_vec;

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .in_fncode  (in_fncode),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_A      (out_A),
        .out_B      (out_B),
        .out_fncode (out_fncode),
        .count      (count),
        .reject     (reject),
        .reject_cnt (reject_cnt)
    );

    assign dut_vec = {in_ready, out_valid, out_A, out_B, out_fncode, count, reject, reject_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_vec();
        logic rdy;
        rdy = (m_q.size() < DEPTH);
        return {rdy, m_ov, m_a, m_b, m_f, 5'(m_q.size()), m_rej, 8'(m_rcnt)};
    endfunction

    // Advance one rising edge, applying the same inputs to the model, then settle.
    task automatic tick();
        bit hs;
        bit good;
        logic [15:0] e;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ov = 0; m_a = 0; m_b = 0; m_f = 0; m_rej = 0; m_rcnt = 0;
        end else begin
            hs   = in_valid && (m_q.size() < DEPTH);
            good = ($countones(in_fncode) == 1);
            if (m_q.size() > 0 && !stall) begin
                e = m_q.pop_front();
                m_a = e[15:12]; m_b = e[11:8]; m_f = e[7:0];
                m_ov = 1;
            end else begin
                m_ov = 0;
            end
            m_rej = hs && !good;
            if (m_rej && m_rcnt < 255) m_rcnt++;
            if (hs && good) m_q.push_back({in_A, in_B, in_fncode});
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; in_valid = 0; in_A = 0; in_B = 0; in_fncode = 0; stall = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec, model_vec());
        end
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || reject_cnt !== 8'd0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_state: got count=%0d ov=%b rcnt=%0d rdy=%b expected 0 0 0 1",
                     count, out_valid, reject_cnt, in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1; in_A = 4'd5; in_B = 4'd6; in_fncode = 8'h01; stall = 0;
        tick();
        in_valid = 0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 5'd1) begin
            n_errors++; $display("FAIL single_latency: got ov=%b count=%0d expected 0 1", out_valid, count);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_A !== 4'd5 || out_B !== 4'd6 || out_fncode !== 8'h01 || count !== 5'd0) begin
            n_errors++;
            $display("FAIL single_issue: got ov=%b A=%0d B=%0d f=%h count=%0d expected 1 5 6 01 0",
                     out_valid, out_A, out_B, out_fncode, count);
        end
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_errors++; $display("FAIL single_vec: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_stall_fill();
        stall = 1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_A = 4'(i); in_B = 4'(15 - i); in_fncode = 8'h01 << (i - 1);
            tick();
        end
        n_checks++;
        if (count !== 5'd4 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL fill_full: got count=%0d rdy=%b ov=%b expected 4 0 0", count, in_ready, out_valid);
        end
        in_A = 4'd9; in_fncode = 8'h10;
        tick();
        n_checks++;
        if (dut_vec !== model_vec() || reject !== 1'b0) begin
            n_errors++; $display("FAIL fill_fifth_ignored: got %h expected %h", dut_vec, model_vec());
        end
        in_valid = 0; stall = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_A !== 4'(i) || dut_vec !== model_vec()) begin
                n_errors++; $display("FAIL drain_order: got ov=%b A=%0d expected 1 %0d", out_valid, out_A, i);
            end
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_A !== 4'd4) begin
            n_errors++; $display("FAIL drain_hold: got ov=%b A=%0d expected 0 4", out_valid, out_A);
        end
    endtask

    task automatic test_reject();
        idle_inputs(); rst = 1; tick(); rst = 0;
        in_valid = 1; in_A = 4'd3; in_B = 4'd3; in_fncode = 8'h03;
        tick();
        n_checks++;
        if (reject !== 1'b1 || out_valid !== 1'b0 || count !== 5'd0) begin
            n_errors++; $display("FAIL reject_multi: got rej=%b ov=%b count=%0d expected 1 0 0", reject, out_valid, count);
        end
        in_fncode = 8'h00;
        tick();
        n_checks++;
        if (reject !== 1'b1 || reject_cnt !== 8'd1 + 8'd1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reject_zero: got rej=%b rcnt=%0d ov=%b expected 1 2 0", reject, reject_cnt, out_valid);
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (reject !== 1'b0 || reject_cnt !== 8'd2 || count !== 5'd0 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reject_pulse_end: got rej=%b rcnt=%0d count=%0d ov=%b", reject, reject_cnt, count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        stall = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_A = 4'(i); in_B = 4'(i + 3); in_fncode = 8'h02;
            tick();
            n_checks++;
            if (count !== 5'd1 || dut_vec !== model_vec() || (i > 0 && (out_valid !== 1'b1 || out_A !== 4'(i - 1)))) begin
                n_errors++;
                $display("FAIL b2b_step%0d: got count=%0d ov=%b A=%0d vec=%h expected vec=%h",
                         i, count, out_valid, out_A, dut_vec, model_vec());
            end
        end
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_A !== 4'd9 || count !== 5'd0) begin
            n_errors++; $display("FAIL b2b_last: got ov=%b A=%0d count=%0d expected 1 9 0", out_valid, out_A, count);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_A = 4'(i + 10); in_B = 4'(i); in_fncode = 8'h40;
            tick();
        end
        rst = 1; in_fncode = 8'h11; stall = 0;
        tick();
        rst = 0; in_valid = 0;
        n_checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || reject_cnt !== 8'd0 || reject !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_state: got count=%0d ov=%b rcnt=%0d rej=%b rdy=%b expected 0 0 0 0 1",
                     count, out_valid, reject_cnt, reject, in_ready);
        end
        in_valid = 1; in_A = 4'd7; in_B = 4'd8; in_fncode = 8'h80;
        tick();
        in_valid = 0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_A !== 4'd7 || out_B !== 4'd8 || out_fncode !== 8'h80 || dut_vec !== model_vec()) begin
            n_errors++; $display("FAIL midreset_push: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_saturate();
        idle_inputs(); rst = 1; tick(); rst = 0;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1;
            in_A = 4'($urandom); in_B = 4'($urandom);
            do in_fncode = 8'($urandom); while ($countones(in_fncode) == 1);
            stall = 1'($urandom);
            tick();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_errors++; $display("FAIL saturate_step%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (reject_cnt !== 8'd255 || count !== 5'd0) begin
            n_errors++; $display("FAIL saturate_final: got rcnt=%0d count=%0d expected 255 0", reject_cnt, count);
        end
        in_valid = 0;
    endtask

    task automatic test_random();
        idle_inputs(); rst = 1; tick(); rst = 0;
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            stall    = ($urandom_range(0, 9) < 4);
            rst      = ($urandom_range(0, 99) == 0);
            in_A = 4'($urandom); in_B = 4'($urandom);
            if ($urandom_range(0, 9) < 8) in_fncode = 8'h01 << $urandom_range(0, 7);
            else in_fncode = 8'($urandom);
            n_checks++;
            if (in_ready !== (m_q.size() < DEPTH)) begin
                n_errors++; $display("FAIL random_ready%0d: got %b expected %b", i, in_ready, m_q.size() < DEPTH);
            end
            tick();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_errors++; $display("FAIL random_step%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_ov = 0; m_a = 0; m_b = 0; m_f = 0; m_rej = 0; m_rcnt = 0;
        test_reset();
        test_single();
        test_stall_fill();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
